// File: rtl/cpu_pkg.sv
// Shared encodings for the 17-opcode multi-cycle core: stages, opcodes,
// datapath select values and the packed control-output bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } stage_e;

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_ADDI  = 5'd3;
  localparam logic [4:0] OP_ANDI  = 5'd4;
  localparam logic [4:0] OP_LW    = 5'd5;
  localparam logic [4:0] OP_LWPOI = 5'd6;
  localparam logic [4:0] OP_SW    = 5'd7;
  localparam logic [4:0] OP_BGT   = 5'd8;
  localparam logic [4:0] OP_BLT   = 5'd9;
  localparam logic [4:0] OP_BEQ   = 5'd10;
  localparam logic [4:0] OP_BNE   = 5'd11;
  localparam logic [4:0] OP_JMP   = 5'd12;
  localparam logic [4:0] OP_CALL  = 5'd13;
  localparam logic [4:0] OP_RET   = 5'd14;
  localparam logic [4:0] OP_PUSH  = 5'd15;
  localparam logic [4:0] OP_POP   = 5'd16;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] TRAP_VEC  = 2'd3;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_STACK = 2'd2;

  typedef struct packed {
    logic rtype;
    logic imm;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic call;
    logic ret;
    logic push;
    logic pop;
    logic illegal;
  } op_class_t;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       ext_src;
    logic       reg_des;
    logic       alu_src;
    logic       j_src;
    logic [1:0] wb_data;
    logic       reg_w1;
    logic       reg_w2;
    logic       mem_read;
    logic       mem_write;
    logic       illegal_op;
    logic       bus_err;
  } ctrl_out_t;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier plus the stage-independent datapath selects.
// Anything above POP, including the unused upper opcode bits, is illegal.
module op_class_decode
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           cls,
  output logic                post_inc,
  output logic                ext_src,
  output logic                reg_des,
  output logic                alu_src,
  output logic                j_src,
  output logic [1:0]          wb_data
);

  logic [4:0] op5;
  logic       sel_imm;

  assign op5 = opcode[4:0];

  always_comb begin
    cls      = '0;
    post_inc = 1'b0;
    sel_imm  = 1'b0;
    j_src    = 1'b0;
    wb_data  = WB_ALU;
    if (opcode > OPCODE_W'(OP_POP)) begin
      cls.illegal = 1'b1;
    end else begin
      case (op5)
        OP_AND, OP_ADD, OP_SUB: cls.rtype = 1'b1;
        OP_ADDI, OP_ANDI: begin
          cls.imm = 1'b1;
          sel_imm = 1'b1;
        end
        OP_LW, OP_LWPOI: begin
          cls.load = 1'b1;
          sel_imm  = 1'b1;
          wb_data  = WB_MEM;
          post_inc = (op5 == OP_LWPOI);
        end
        OP_SW: begin
          cls.store = 1'b1;
          sel_imm   = 1'b1;
        end
        OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
          cls.branch = 1'b1;
          sel_imm    = 1'b1;
        end
        OP_JMP:  cls.jump = 1'b1;
        OP_CALL: cls.call = 1'b1;
        OP_RET: begin
          cls.ret = 1'b1;
          j_src   = 1'b1;
        end
        OP_PUSH: cls.push = 1'b1;
        OP_POP: begin
          cls.pop = 1'b1;
          wb_data = WB_STACK;
        end
        default: cls.illegal = 1'b1;
      endcase
    end
  end

  assign ext_src = sel_imm;
  assign reg_des = sel_imm;
  assign alu_src = sel_imm;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with memory handshake timeout,
// global stall, illegal-opcode trap and a retired-instruction counter.
//
// state | meaning
// IF    | fetch: mem_read until mem_ready, then load IR
// ID    | decode: trap illegal opcodes, resolve JMP
// EX    | ALU cycle: resolve branches from live flags
// MEM   | data/stack access, held until mem_ready or timeout
// WB    | register write-back and PC+1
module multicycle_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MEM_TO   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                carry_flag,
  input  logic                neg_flag,
  input  logic                mem_ready,
  input  logic                stall,
  output logic [2:0]          state,
  output logic [1:0]          pc_src,
  output logic                pc_write,
  output logic                ir_write,
  output logic                ext_src,
  output logic                reg_des,
  output logic                alu_src,
  output logic                j_src,
  output logic [1:0]          wb_data,
  output logic                reg_w1,
  output logic                reg_w2,
  output logic                mem_read,
  output logic                mem_write,
  output logic                illegal_op,
  output logic                bus_err,
  output logic [CNT_W-1:0]    retired_cnt
);

  localparam int WAIT_W = (MEM_TO < 2) ? 1 : $clog2(MEM_TO);

  stage_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  op_class_t  cls;
  logic       post_inc, dec_ext, dec_reg_des, dec_alu, dec_j;
  logic [1:0] dec_wb;
  logic       taken, to_hit, waiting, retire;
  logic       unused_carry;
  ctrl_out_t  o;

  assign unused_carry = carry_flag;

  op_class_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode   (opcode),
    .cls      (cls),
    .post_inc (post_inc),
    .ext_src  (dec_ext),
    .reg_des  (dec_reg_des),
    .alu_src  (dec_alu),
    .j_src    (dec_j),
    .wb_data  (dec_wb)
  );

  // BGT/BLT/BEQ/BNE are 8..11, so the low two opcode bits pick the condition.
  always_comb begin
    case (opcode[1:0])
      2'b00:   taken = ~neg_flag & ~zero_flag;
      2'b01:   taken = neg_flag;
      2'b10:   taken = zero_flag;
      default: taken = ~zero_flag;
    endcase
  end

  assign waiting = ((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready;
  assign to_hit  = (MEM_TO != 0) && waiting && !stall
                   && (wait_q == WAIT_W'(MEM_TO - 1));

  always_comb begin
    o       = '0;
    state_d = state_q;
    if (state_q inside {ST_ID, ST_EX, ST_MEM, ST_WB}) begin
      o.ext_src = dec_ext;
      o.reg_des = dec_reg_des;
      o.alu_src = dec_alu;
      o.j_src   = dec_j;
      o.wb_data = dec_wb;
    end
    case (state_q)
      ST_IF: begin
        o.mem_read = ~to_hit;
        if (mem_ready) begin
          o.ir_write = 1'b1;
          state_d    = ST_ID;
        end else if (to_hit) begin
          o.bus_err  = 1'b1;
          o.pc_src   = TRAP_VEC;
          o.pc_write = 1'b1;
        end
      end
      ST_ID: begin
        if (cls.illegal) begin
          o.illegal_op = 1'b1;
          o.pc_src     = TRAP_VEC;
          o.pc_write   = 1'b1;
          state_d      = ST_IF;
        end else if (cls.jump) begin
          o.pc_src   = PC_JUMP;
          o.pc_write = 1'b1;
          state_d    = ST_IF;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        if (cls.rtype || cls.imm) begin
          state_d = ST_WB;
        end else if (cls.branch) begin
          o.pc_src   = taken ? PC_BRANCH : PC_INC;
          o.pc_write = 1'b1;
          state_d    = ST_IF;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        o.mem_read  = (cls.load | cls.pop | cls.ret) & ~to_hit;
        o.mem_write = (cls.store | cls.call | cls.push) & ~to_hit;
        if (mem_ready) begin
          if (cls.load || cls.pop) begin
            state_d = ST_WB;
          end else begin
            o.pc_src   = (cls.call || cls.ret) ? PC_JUMP : PC_INC;
            o.pc_write = 1'b1;
            state_d    = ST_IF;
          end
        end else if (to_hit) begin
          o.bus_err  = 1'b1;
          o.pc_src   = TRAP_VEC;
          o.pc_write = 1'b1;
          state_d    = ST_IF;
        end
      end
      ST_WB: begin
        o.reg_w1   = 1'b1;
        o.reg_w2   = post_inc;
        o.pc_write = 1'b1;
        state_d    = ST_IF;
      end
      default: state_d = ST_IF;
    endcase

    // Stall freezes the sequencer; trap pulses are deferred with it.
    if (stall) begin
      state_d      = state_q;
      o.pc_write   = 1'b0;
      o.ir_write   = 1'b0;
      o.reg_w1     = 1'b0;
      o.reg_w2     = 1'b0;
      o.mem_write  = 1'b0;
      o.illegal_op = 1'b0;
      o.bus_err    = 1'b0;
    end
    if (!rst_n) begin
      o = '0;
    end
  end

  assign retire    = o.pc_write & ~o.illegal_op & ~o.bus_err;
  assign retired_d = retired_q + CNT_W'(retire);

  always_comb begin
    wait_d = wait_q;
    if (!stall) begin
      if ((state_d != state_q) || o.bus_err) begin
        wait_d = '0;
      end else if (waiting && (wait_q != {WAIT_W{1'b1}})) begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IF;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state       = state_q;
  assign pc_src      = o.pc_src;
  assign pc_write    = o.pc_write;
  assign ir_write    = o.ir_write;
  assign ext_src     = o.ext_src;
  assign reg_des     = o.reg_des;
  assign alu_src     = o.alu_src;
  assign j_src       = o.j_src;
  assign wb_data     = o.wb_data;
  assign reg_w1      = o.reg_w1;
  assign reg_w2      = o.reg_w2;
  assign mem_read    = o.mem_read;
  assign mem_write   = o.mem_write;
  assign illegal_op  = o.illegal_op;
  assign bus_err     = o.bus_err;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed scenarios plus a random instruction
// stream, each cycle checked against an instruction-level reference model.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MEM_TO   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [OPCODE_W-1:0] opcode;
  logic                zero_flag, carry_flag, neg_flag, mem_ready, stall;
  logic [2:0]          state;
  logic [1:0]          pc_src, wb_data;
  logic                pc_write, ir_write, ext_src, reg_des, alu_src, j_src;
  logic                reg_w1, reg_w2, mem_read, mem_write, illegal_op, bus_err;
  logic [CNT_W-1:0]    retired_cnt;
  logic [18:0]         outv;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ret = 0;
  bit dir_stall = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .neg_flag(neg_flag), .mem_ready(mem_ready),
    .stall(stall), .state(state), .pc_src(pc_src), .pc_write(pc_write),
    .ir_write(ir_write), .ext_src(ext_src), .reg_des(reg_des), .alu_src(alu_src),
    .j_src(j_src), .wb_data(wb_data), .reg_w1(reg_w1), .reg_w2(reg_w2),
    .mem_read(mem_read), .mem_write(mem_write), .illegal_op(illegal_op),
    .bus_err(bus_err), .retired_cnt(retired_cnt)
  );

  assign outv = {state, pc_src, pc_write, ir_write, ext_src, reg_des, alu_src, j_src,
                 wb_data, reg_w1, reg_w2, mem_read, mem_write, illegal_op, bus_err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // {ext_src, reg_des, alu_src, j_src, wb_data} from the opcode table.
  function automatic logic [5:0] sel_of(input int op);
    bit imm;
    logic [1:0] wb;
    imm = (op >= 3) && (op <= 11);
    wb  = (op == 5 || op == 6) ? 2'd1 : (op == 16) ? 2'd2 : 2'd0;
    return {imm, imm, imm, (op == 14), wb};
  endfunction

  // One clock: drive inputs, check the combinational outputs, advance.
  task automatic cyc(input int st, input int op, input bit s, input bit r,
                     input logic [1:0] pcs, input bit pcw, input bit irw,
                     input bit rw1, input bit rw2, input bit mr, input bit mw,
                     input bit ill, input bit be);
    logic [5:0]  sel;
    logic [2:0]  st3;
    logic [18:0] e;
    stall     = s;
    mem_ready = r;
    #1;
    sel = (st == 0) ? 6'd0 : sel_of(op);
    st3 = st[2:0];
    if (s) begin
      pcw = 0; irw = 0; rw1 = 0; rw2 = 0; mw = 0; ill = 0; be = 0;
    end
    e = {st3, pcs, pcw, irw, sel, rw1, rw2, mr, mw, ill, be};
    check_eq($sformatf("st%0d_op%0d_stall%0d_outputs", st, op, s), {13'd0, outv}, {13'd0, e});
    check_eq($sformatf("st%0d_op%0d_retired", st, op), {28'd0, retired_cnt}, exp_ret);
    if (pcw && !ill && !be) exp_ret = (exp_ret + 1) % (1 << CNT_W);
    @(negedge clk);
  endtask

  // Handshaked access (IF fetch or MEM). dly<0 selects random ready/stall.
  task automatic access(input int st, input int op, input int dly, output bit trapped);
    int waits;
    bit rd, wr, slow;
    waits   = 0;
    trapped = 1'b0;
    rd   = (st == 0) || op == 5 || op == 6 || op == 14 || op == 16;
    wr   = (st == 3) && (op == 7 || op == 13 || op == 15);
    slow = ($urandom_range(0, 2) == 0);
    for (int it = 0; it < 200; it++) begin
      bit s, r, tmo, pcw, irw;
      logic [1:0] pcs;
      if (dly < 0) begin
        s = ($urandom_range(0, 4) == 0);
        r = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      end else begin
        s = dir_stall && (it == 2 || it == 3);
        r = (waits == dly);
      end
      if (it >= 150) begin
        s = 1'b0;
        r = 1'b1;
      end
      tmo = !s && !r && (waits == MEM_TO - 1);
      pcs = 2'd0; pcw = 1'b0; irw = 1'b0;
      if (r) begin
        if (st == 0) irw = 1'b1;
        else if (op == 13 || op == 14) begin pcs = 2'd1; pcw = 1'b1; end
        else if (op == 7 || op == 15) pcw = 1'b1;
        cyc(st, op, s, 1'b1, pcs, pcw, irw, 0, 0, rd, wr, 0, 0);
        if (!s) return;
      end else if (tmo) begin
        cyc(st, op, 1'b0, 1'b0, 2'd3, 1, 0, 0, 0, 0, 0, 0, 1);
        trapped = 1'b1;
        return;
      end else begin
        cyc(st, op, s, 1'b0, 2'd0, 0, 0, 0, 0, rd, wr, 0, 0);
        if (!s) waits++;
      end
    end
  endtask

  // Single-cycle stage; random stalls and stray mem_ready unless deterministic.
  task automatic plain(input int st, input int op, input bit det, input logic [1:0] pcs,
                       input bit pcw, input bit rw1, input bit rw2, input bit ill);
    for (int it = 0; it < 100; it++) begin
      bit s;
      s = !det && (it < 50) && ($urandom_range(0, 3) == 0);
      cyc(st, op, s, det ? 1'b0 : 1'($urandom_range(0, 1)), pcs, pcw, 0, rw1, rw2, 0, 0, ill, 0);
      if (!s) return;
    end
  endtask

  task automatic run_instr(input int op, input bit zf, input bit nf,
                           input int if_dly, input int mem_dly);
    bit tr, det, tk;
    det        = (if_dly >= 0);
    opcode     = op[OPCODE_W-1:0];
    zero_flag  = zf;
    neg_flag   = nf;
    carry_flag = 1'($urandom_range(0, 1));
    access(0, op, if_dly, tr);
    if (tr) return;
    if (op > 16) begin plain(1, op, det, 2'd3, 1, 0, 0, 1); return; end
    if (op == 12) begin plain(1, op, det, 2'd1, 1, 0, 0, 0); return; end
    plain(1, op, det, 2'd0, 0, 0, 0, 0);
    if (op >= 8 && op <= 11) begin
      tk = (op == 8) ? (!nf && !zf) : (op == 9) ? nf : (op == 10) ? zf : !zf;
      plain(2, op, det, tk ? 2'd2 : 2'd0, 1, 0, 0, 0);
      return;
    end
    plain(2, op, det, 2'd0, 0, 0, 0, 0);
    if (op >= 5) begin
      access(3, op, mem_dly, tr);
      if (tr) return;
      if (!(op == 5 || op == 6 || op == 16)) return;
    end
    plain(4, op, det, 2'd0, 1, 1, (op == 6), 0);
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; zero_flag = 0; carry_flag = 0; neg_flag = 0;
    mem_ready = 0; stall = 0;
    #2;
    check_eq("reset_outputs", {13'd0, outv}, 32'd0);
    check_eq("reset_retired", {28'd0, retired_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(1, 0, 0, 0, 0);       // ADD
    run_instr(6, 0, 0, 0, 3);       // LWPOI, ready after 3 wait cycles
    run_instr(10, 1, 0, 0, 0);      // BEQ taken
    run_instr(11, 1, 0, 0, 0);      // BNE not taken
    run_instr(63, 0, 0, 0, 0);      // illegal
    dir_stall = 1'b1;
    run_instr(7, 0, 0, 0, 99);      // SW timeout with stall mid-wait
    dir_stall = 1'b0;

    for (int i = 0; i < 300; i++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 63)) : int'($urandom_range(0, 16));
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
    end

    // Asynchronous reset in the middle of a SW wait.
    opcode = 6'd7;
    cyc(0, 7, 0, 1, 2'd0, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc(1, 7, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(2, 7, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(3, 7, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", {13'd0, outv}, 32'd0);
    check_eq("async_reset_retired", {28'd0, retired_cnt}, 32'd0);
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(12, 0, 0, 0, 0);      // JMP after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
